// File: rtl/bcd_time_of_day_counter.sv
// bcd_time_of_day_counter
// 24-hour BCD time-of-day keeper (HH:MM:SS). It advances on rising edges of
// the upstream 1 Hz square wave in run mode. In set mode the minute and hour
// buttons adjust the time.
module bcd_time_of_day_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sec_tick,
  input  logic       i_run,
  input  logic       i_inc_min,
  input  logic       i_inc_hr,
  input  logic       i_clr_sec,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_hr_ones,
  output logic [3:0] o_hr_tens,
  output logic       o_tick_pulse,
  output logic       o_min_carry,
  output logic       o_day_carry
);

  // Previous samples of the three edge-detected inputs.
  logic       tick_d;
  logic       min_d;
  logic       hr_d;

  // Each time field is held as one byte: tens digit in [7:4], ones digit in [3:0].
  logic [7:0] sec_q;
  logic [7:0] min_q;
  logic [7:0] hr_q;
  logic [7:0] sec_nx;
  logic [7:0] min_nx;
  logic [7:0] hr_nx;

  logic       tick_edge;
  logic       min_edge;
  logic       hr_edge;
  logic       run_tick;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hr_wrap;
  logic       min_carry_nx;
  logic       day_carry_nx;

  // Advance a 00-59 BCD pair by one, wrapping 59 to 00.
  function automatic logic [7:0] inc_bcd_60(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  // Advance a 00-23 BCD pair by one, wrapping 23 to 00.
  function automatic logic [7:0] inc_bcd_24(input logic [7:0] v);
    if (v == 8'h23)     return 8'h00;
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    return {v[7:4] + 4'd1, 4'd0};
  endfunction

  assign tick_edge = i_sec_tick & ~tick_d;
  assign min_edge  = i_inc_min  & ~min_d;
  assign hr_edge   = i_inc_hr   & ~hr_d;

  assign sec_wrap  = (sec_q == 8'h59);
  assign min_wrap  = (min_q == 8'h59);
  assign hr_wrap   = (hr_q  == 8'h23);

  // A clear in the tick cycle swallows the tick as far as counting goes.
  assign run_tick     = i_run & tick_edge & ~i_clr_sec;
  assign min_carry_nx = run_tick & sec_wrap;
  assign day_carry_nx = min_carry_nx & min_wrap & hr_wrap;

  // Next-state of the three time fields: clear, run-mode carry chain, set-mode buttons.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    sec_nx = sec_q;
    min_nx = min_q;
    hr_nx  = hr_q;

    if (i_clr_sec)     sec_nx = 8'h00;
    else if (run_tick) sec_nx = inc_bcd_60(sec_q);

    if (i_run) begin
      if (min_carry_nx)            min_nx = inc_bcd_60(min_q);
      if (min_carry_nx & min_wrap) hr_nx  = inc_bcd_24(hr_q);
    end else begin
      if (min_edge) min_nx = inc_bcd_60(min_q);
      if (hr_edge)  hr_nx  = inc_bcd_24(hr_q);
    end
  end

  // Time, edge-history and strobe registers; reset wins over every other input.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      // Edge history resets high so an input already high at release is not an edge.
      tick_d       <= 1'b1;
      min_d        <= 1'b1;
      hr_d         <= 1'b1;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hr_q         <= 8'h00;
      o_tick_pulse <= 1'b0;
      o_min_carry  <= 1'b0;
      o_day_carry  <= 1'b0;
    end else begin
      tick_d       <= i_sec_tick;
      min_d        <= i_inc_min;
      hr_d         <= i_inc_hr;
      sec_q        <= sec_nx;
      min_q        <= min_nx;
      hr_q         <= hr_nx;
      o_tick_pulse <= tick_edge;
      o_min_carry  <= min_carry_nx;
      o_day_carry  <= day_carry_nx;
    end
  end

  assign o_sec_ones = sec_q[3:0];
  assign o_sec_tens = sec_q[7:4];
  assign o_min_ones = min_q[3:0];
  assign o_min_tens = min_q[7:4];
  assign o_hr_ones  = hr_q[3:0];
  assign o_hr_tens  = hr_q[7:4];

endmodule

// File: tb/tb_bcd_time_of_day_counter.sv
// tb_bcd_time_of_day_counter
// Directed stimulus with a scoreboard. The driver pushes the expected
// post-edge state for every clock it drives. The monitor pops one entry
// after each rising edge and compares it against the outputs.
module tb_bcd_time_of_day_counter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_sec_tick;
  logic       i_run;
  logic       i_inc_min;
  logic       i_inc_hr;
  logic       i_clr_sec;
  logic [3:0] o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hr_ones, o_hr_tens;
  logic       o_tick_pulse, o_min_carry, o_day_carry;

  bcd_time_of_day_counter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sec_tick   (i_sec_tick),
    .i_run        (i_run),
    .i_inc_min    (i_inc_min),
    .i_inc_hr     (i_inc_hr),
    .i_clr_sec    (i_clr_sec),
    .o_sec_ones   (o_sec_ones),
    .o_sec_tens   (o_sec_tens),
    .o_min_ones   (o_min_ones),
    .o_min_tens   (o_min_tens),
    .o_hr_ones    (o_hr_ones),
    .o_hr_tens    (o_hr_tens),
    .o_tick_pulse (o_tick_pulse),
    .o_min_carry  (o_min_carry),
    .o_day_carry  (o_day_carry)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] t;
    logic        tp;
    logic        mc;
    logic        dc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   tick_seen = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {to_bcd(h), to_bcd(m), to_bcd(s)};
  endfunction

  // Monitor: one scoreboard entry per driven clock edge, compared 1 ns after it.
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (o_tick_pulse === 1'b1) tick_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name,
            {5'd0, o_hr_tens, o_hr_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones,
             o_tick_pulse, o_min_carry, o_day_carry},
            {5'd0, e.t, e.tp, e.mc, e.dc});
    end
  end

  // One clock: wait for the edge, record what it must produce, return at the falling edge.
  task automatic cyc(input logic [23:0] t, input logic tp, input logic mc, input logic dc,
                     input string name);
    exp_t e;
    @(posedge i_clk);
    e.t = t; e.tp = tp; e.mc = mc; e.dc = dc; e.name = name;
    sb.push_back(e);
    @(negedge i_clk);
  endtask

  // One full square-wave period of the 1 Hz input (high one cycle, low one cycle).
  task automatic tick(input logic [23:0] t, input logic mc, input logic dc, input string name);
    i_sec_tick = 1'b1;
    cyc(t, 1'b1, mc, dc, name);
    i_sec_tick = 1'b0;
    cyc(t, 1'b0, 1'b0, 1'b0, {name, "_low"});
  endtask

  // One button press and release.
  task automatic press(input logic do_min, input logic do_hr, input logic [23:0] t,
                       input string name);
    i_inc_min = do_min;
    i_inc_hr  = do_hr;
    cyc(t, 1'b0, 1'b0, 1'b0, name);
    i_inc_min = 1'b0;
    i_inc_hr  = 1'b0;
    cyc(t, 1'b0, 1'b0, 1'b0, {name, "_rel"});
  endtask

  initial begin
    int base;
    i_rst = 1'b1; i_sec_tick = 1'b0; i_run = 1'b0;
    i_inc_min = 1'b0; i_inc_hr = 1'b0; i_clr_sec = 1'b0;

    // Reset state
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "reset0");
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "reset1");
    i_rst = 1'b0; i_run = 1'b1;
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "post_reset");

    // 60 ticks in run mode: 00:01:00, one minute carry on the 60th
    base = tick_seen;
    for (int i = 1; i <= 60; i++)
      tick(hms(0, i / 60, i % 60), (i == 60), 1'b0, "run60");
    check("tick_pulse_count", 32'(tick_seen - base), 32'd60);

    // Preload 23:59:58 through set mode, clear and run ticks
    i_run = 1'b0;
    for (int h = 1; h <= 23; h++) press(1'b0, 1'b1, hms(h, 1, 0), "set_hr");
    for (int m = 2; m <= 59; m++) press(1'b1, 1'b0, hms(23, m, 0), "set_min");
    i_clr_sec = 1'b1;
    cyc(hms(23, 59, 0), 1'b0, 1'b0, 1'b0, "clr_preload");
    i_clr_sec = 1'b0;
    i_run = 1'b1;
    for (int s = 1; s <= 58; s++) tick(hms(23, 59, s), 1'b0, 1'b0, "run_to_58");
    tick(hms(23, 59, 59), 1'b0, 1'b0, "tick_59");
    tick(hms(0, 0, 0), 1'b1, 1'b1, "day_rollover");

    // Set mode minute wrap without hour carry, held button, simultaneous buttons
    for (int s = 1; s <= 7; s++) tick(hms(0, 0, s), 1'b0, 1'b0, "run_to_07");
    i_run = 1'b0;
    for (int m = 1; m <= 59; m++) press(1'b1, 1'b0, hms(0, m, 7), "set_min59");
    press(1'b1, 1'b0, hms(0, 0, 7), "min_wrap_no_hr");
    i_inc_min = 1'b1;
    cyc(hms(0, 1, 7), 1'b0, 1'b0, 1'b0, "held_first");
    for (int i = 0; i < 9; i++) cyc(hms(0, 1, 7), 1'b0, 1'b0, 1'b0, "held_more");
    i_inc_min = 1'b0;
    cyc(hms(0, 1, 7), 1'b0, 1'b0, 1'b0, "held_release");
    for (int h = 1; h <= 22; h++) press(1'b0, 1'b1, hms(h, 1, 7), "set_hr22");
    for (int m = 2; m <= 58; m++) press(1'b1, 1'b0, hms(22, m, 7), "set_min58");
    press(1'b1, 1'b1, hms(23, 59, 7), "both_buttons");

    // Ticks in set mode: pulse only, no time change, no carries
    for (int i = 0; i < 5; i++) tick(hms(23, 59, 7), 1'b0, 1'b0, "set_tick");
    press(1'b1, 1'b0, hms(23, 0, 7), "set_min_wrap_23");
    press(1'b0, 1'b1, hms(0, 0, 7), "set_hr_wrap");

    // Run mode: buttons ignored, clear beats tick at 00:00:59
    i_run = 1'b1;
    press(1'b1, 1'b1, hms(0, 0, 7), "run_btn_ignored");
    for (int s = 8; s <= 59; s++) tick(hms(0, 0, s), 1'b0, 1'b0, "run_to_59");
    i_clr_sec = 1'b1;
    tick(hms(0, 0, 0), 1'b0, 1'b0, "clr_vs_tick");
    i_clr_sec = 1'b0;
    tick(hms(0, 0, 1), 1'b0, 1'b0, "after_clr");

    // Reach 12:34:56, then reset with tick and button high
    i_run = 1'b0;
    for (int h = 1; h <= 12; h++) press(1'b0, 1'b1, hms(h, 0, 1), "set_hr12");
    for (int m = 1; m <= 34; m++) press(1'b1, 1'b0, hms(12, m, 1), "set_min34");
    i_run = 1'b1;
    for (int s = 2; s <= 56; s++) tick(hms(12, 34, s), 1'b0, 1'b0, "run_to_56");
    i_rst = 1'b1; i_sec_tick = 1'b1; i_inc_min = 1'b1;
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "reset_mid");
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "reset_hold");
    i_rst = 1'b0; i_inc_min = 1'b0;
    for (int i = 0; i < 3; i++) cyc(24'h0, 1'b0, 1'b0, 1'b0, "high_at_release");
    i_sec_tick = 1'b0;
    cyc(24'h0, 1'b0, 1'b0, 1'b0, "tick_low");
    tick(hms(0, 0, 1), 1'b0, 1'b0, "first_real_tick");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge i_clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
